// File: rtl/prio_encoder_q.sv
// Registered N-to-log2(N) request encoder with pending capture and valid/ready hold.
// Define PRIO_ENC_RR_EN for round-robin selection; the default is fixed highest-index priority.
module prio_encoder_q #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic [N-1:0] iReq,
  input  logic         iReady,
  input  logic         iClrDrop,
  output logic         oValid,
  output logic [W-1:0] oData,
  output logic [N-1:0] oPending,
  output logic         oDrop
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pend;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] sel;
  logic         hs;

  assign oValid   = (state == HOLD);
  assign oPending = pend;
  assign hs       = oValid & iReady;

  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < N; i++) clr[i] = hs && (oData == W'(i));
  end

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] last;
  logic [N-1:0] below;

  // Indices below last are searched first (descending); if none, wrap to the top.
  always_comb begin
    below = '0;
    for (int unsigned i = 0; i < N; i++) below[i] = (W'(i) < last);
    cand = pend & below;
    if (cand == '0) cand = pend;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)    last <= '0;
    else if (hs) last <= oData;
  end
`else
  always_comb cand = pend;
`endif

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) sel = W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pend != '0) state_nxt = HOLD;
      HOLD: if (iReady)     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A request on the bit being accepted re-arms it without counting as a drop.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pend  <= '0;
      oData <= '0;
      oDrop <= 1'b0;
    end else begin
      pend  <= (pend & ~clr) | iReq;
      oDrop <= (|(iReq & pend & ~clr)) | (oDrop & ~iClrDrop);
      if (state == IDLE && pend != '0) oData <= sel;
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Randomised and directed bench for prio_encoder_q (N=8 and N=5 instances)
// against a cycle-level reference model.
module tb_prio_encoder_q;

  typedef struct {
    logic [63:0] pend;
    bit          valid;
    int          data;
    bit          drop;
    int          last;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       ready = 1'b0;
  logic       clrdrop = 1'b0;

  logic       v8, drop8, v5, drop5;
  logic [2:0] data8, data5;
  logic [7:0] pend8;
  logic [4:0] pend5;

  int   total = 0;
  int   bad = 0;
  mdl_t m8, m5;

  always #5 clk = ~clk;

  prio_encoder_q #(.N(8), .W(3)) dut8 (
    .iClk(clk), .iRst(rst), .iReq(req), .iReady(ready), .iClrDrop(clrdrop),
    .oValid(v8), .oData(data8), .oPending(pend8), .oDrop(drop8)
  );

  prio_encoder_q #(.N(5), .W(3)) dut5 (
    .iClk(clk), .iRst(rst), .iReq(req[4:0]), .iReady(ready), .iClrDrop(clrdrop),
    .oValid(v5), .oData(data5), .oPending(pend5), .oDrop(drop5)
  );

  function automatic mdl_t zero_m();
    mdl_t z;
    z.pend = '0; z.valid = 1'b0; z.data = 0; z.drop = 1'b0; z.last = 0;
    return z;
  endfunction

  // Descending search from the starting index, wrapping modulo n.
  function automatic int pick(logic [63:0] p, int n, int last);
    int start;
`ifdef PRIO_ENC_RR_EN
    start = (last + n - 1) % n;
`else
    start = n - 1;
`endif
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (start - k + n) % n;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic mdl_t step(mdl_t m, int n, logic [63:0] rq, bit rd, bit cd);
    mdl_t        r;
    logic [63:0] clr;
    logic [63:0] msk;
    r   = m;
    clr = '0;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    rq  = rq & msk;
    if (m.valid && rd) clr = 64'd1 << m.data;
    r.drop = ((rq & m.pend & ~clr) != 0) || (m.drop && !cd);
    if (m.valid) begin
      if (rd) begin
        r.valid = 1'b0;
        r.last  = m.data;
      end
    end else if (m.pend != 0) begin
      r.data  = pick(m.pend, n, m.last);
      r.valid = 1'b1;
    end
    r.pend = (m.pend & ~clr) | rq;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("v8", v8, m8.valid);
    chk("data8", data8, m8.data);
    chk("pend8", pend8, m8.pend);
    chk("drop8", drop8, m8.drop);
    chk("v5", v5, m5.valid);
    chk("data5", data5, m5.data);
    chk("pend5", pend5, m5.pend);
    chk("drop5", drop5, m5.drop);
  endtask

  task automatic tick(input logic [7:0] r, input bit rd, input bit cd);
    req = r; ready = rd; clrdrop = cd;
    @(posedge clk);
    m8 = step(m8, 8, {56'd0, r}, rd, cd);
    m5 = step(m5, 5, {56'd0, r}, rd, cd);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int g[$];
    int exp5[6];
`ifdef PRIO_ENC_RR_EN
    exp5 = '{4, 3, 2, 1, 0, 4};
`else
    exp5 = '{4, 4, 4, 4, 4, 4};
`endif
    m8 = zero_m();
    m5 = zero_m();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_valid", v8, 0);
    rst = 1'b0;

    // single request, held grant, then accept
    tick(8'h01, 0, 0);
    tick(8'h00, 0, 0);
    chk("t1_valid", v8, 1);
    chk("t1_data", data8, 0);
    repeat (5) tick(8'h00, 0, 0);
    chk("t1_hold", data8, 0);
    tick(8'h00, 1, 0);
    chk("t1_pend", pend8, 0);
    chk("t1_vlow", v8, 0);

    // 0xA4 drains as 7,5,2
    tick(8'hA4, 1, 0);
    g.delete();
    repeat (6) begin
      tick(8'h00, 1, 0);
      if (v8) g.push_back(int'(data8));
    end
    chk("t2_count", g.size(), 3);
    if (g.size() == 3) begin
      chk("t2_g0", g[0], 7);
      chk("t2_g1", g[1], 5);
      chk("t2_g2", g[2], 2);
    end
    chk("t2_pend", pend8, 0);

    // re-request on the bit being accepted
    tick(8'h08, 0, 0);
    tick(8'h00, 0, 0);
    chk("t3_data", data8, 3);
    tick(8'h08, 1, 0);
    chk("t3_nodrop", drop8, 0);
    chk("t3_pend", pend8, 8'h08);
    tick(8'h00, 0, 0);
    chk("t3_regrant", v8, 1);
    tick(8'h00, 1, 0);

    // coalesced request sets drop; clear removes it
    tick(8'h10, 0, 0);
    tick(8'h00, 0, 0);
    tick(8'h10, 0, 0);
    chk("t4_drop", drop8, 1);
    tick(8'h00, 0, 1);
    chk("t4_clr", drop8, 0);
    tick(8'h00, 1, 0);

    // asynchronous reset mid-hold
    tick(8'hFF, 0, 0);
    tick(8'h00, 0, 0);
    chk("t5_hold", v8, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_v", v8, 0);
    chk("t5_data", data8, 0);
    chk("t5_pend", pend8, 0);
    chk("t5_drop", drop8, 0);
    m8 = zero_m();
    m5 = zero_m();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick(8'h00, 1, 0);
    chk("t5_idle", v8, 0);

    // N=5 sequence under sustained requests
    g.delete();
    repeat (13) begin
      tick(8'h1F, 1, 0);
      if (v5) begin
        g.push_back(int'(data5));
        chk("t6_range", data5 <= 3'd4, 1);
      end
    end
    chk("t6_count", g.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < g.size()) chk($sformatf("t6_g%0d", i), g[i], exp5[i]);
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      tick(r, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_q.md
# prio_encoder_q

Parametrised, registered N-to-log2(N) request encoder with pending capture and a valid/ready output handshake. Each request bit is latched into a pending register. The highest-priority pending index is presented on a held output until the consumer accepts it, and the accepted bit is then cleared. It is the multi-source successor of the combinational 8-to-3 encoder: it serves interrupt and event sources that pulse for one cycle and must not be lost while the consumer is busy.

## Interface
- N, default 8: number of request inputs, 2..64.
- W, default 3: index width; must equal ceil(log2(N)).
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iReq  in  N  request bits, sampled every cycle; a pulse or a level both register as a request.
- iReady  in  1  consumer accepts oData when high together with oValid.
- iClrDrop  in  1  synchronous clear of oDrop.
- oValid  out  1  oData holds a granted index.
- oData  out  W  granted request index.
- oPending  out  N  current pending register.
- oDrop  out  1  sticky flag: a request arrived on a bit that was already pending, so it was coalesced.

## Operation
- Pending update each cycle:
  - pend_next = (pend & ~clr) | iReq.
  - clr is the one-hot of oData when oValid && iReady, otherwise 0.
  - A new iReq on the bit being accepted in the same cycle wins, so the bit stays pending.
- State machine:
  - Two states, IDLE and HOLD.
  - IDLE: if pend != 0, then oData <= selected index, oValid <= 1, and the state moves to HOLD. Otherwise stay in IDLE with oValid = 0.
  - HOLD: oData and oValid stay stable until iReady. On handshake, clear the bit, set oValid <= 0 and return to IDLE. This gives one bubble cycle per grant.
- Selection without the configuration macro is fixed priority: the highest set index wins. For example, pend = 8'b1010_0000 selects 7.
- The pending bit of a held grant remains set until the handshake. Selection in IDLE only considers pend as registered.
- oData holds its last value while oValid = 0. oData never exceeds N-1.
- oDrop rules:
  - oDrop sets on iReq[k] && pend[k] && !clr[k].
  - iClrDrop clears oDrop; a set in the same cycle wins.
- Reset values: pend = 0, state = IDLE, oValid = 0, oData = 0, oDrop = 0, oPending = 0. Reset during HOLD discards the grant and all pending requests.

## Timing
- Request to valid: an iReq bit high in cycle t sets pend at the end of cycle t. oValid is high in cycle t+2 if the block was idle.
- Handshake completes in the cycle where oValid && iReady are both high. oValid is low in the next cycle. The next grant appears one cycle after that if pend is still nonzero.
- Sustained throughput is one grant per 2 cycles.
- iReady while oValid = 0 is ignored.
- oPending is a direct register output with no combinational path from inputs to outputs.

## Configuration
- PRIO_ENC_RR_EN undefined: fixed priority as above.
- PRIO_ENC_RR_EN defined: round-robin selection.
  - A W-bit pointer last, reset to 0, records each accepted index.
  - The search starts at last-1 and descends, wrapping from 0 to N-1. After reset the first search therefore starts at N-1.
  - last updates only on handshake, not on grant.
  - All other behaviour is unchanged.

## Test plan
- Reset, then a one-cycle iReq = 8'h01 → oValid = 1 with oData = 0 two cycles later. Hold iReady = 0 for 5 cycles → oData stays 0. Assert iReady → pend = 0 and oValid = 0.
- iReq = 8'hA4 for one cycle with iReady tied high → grants 7, 5, 2 with one idle cycle between each, then pend = 0.
- During HOLD of index 3, pulse iReq[3] in the handshake cycle → bit 3 stays pending and is regranted. oDrop stays 0 because the bit was being cleared.
- With pend[4] = 1 and iReady = 0, pulse iReq[4] → oDrop = 1. iClrDrop → oDrop = 0.
- Assert iRst asynchronously mid-HOLD with pend = 8'hFF → all outputs go to 0 immediately and no grant follows without new requests.
- N = 5 and W = 3, with PRIO_ENC_RR_EN defined: hold iReq = 5'b11111 with iReady high → grant sequence 4, 3, 2, 1, 0, 4, … and oData is never above 4. Without the macro → 4 is granted repeatedly.
